// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths and MEM/WB stage types for the memory stage
package memory_pkg;

  localparam int XLEN         = 64;
  localparam int REG_IDX_W    = 5;
  localparam int DMEM_DEPTH   = 1024;
  localparam int DMEM_IDX_LSB = 3;
  localparam int DMEM_IDX_MSB = 12;
  localparam int DMEM_IDX_W   = DMEM_IDX_MSB - DMEM_IDX_LSB + 1;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [DMEM_IDX_W-1:0] dmem_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     mem_to_reg;
    logic     reg_write;
    xlen_t    alu_result;
    xlen_t    mem_data;
  } mem_wb_t;

  // Doubleword index; byte offset and upper bits are dropped so addresses wrap at 8 KiB.
  function automatic dmem_idx_t dmem_index(input xlen_t addr);
    return addr[DMEM_IDX_MSB:DMEM_IDX_LSB];
  endfunction

endpackage

// File: rtl/memory_data_memory.sv
// rtl/memory_data_memory.sv - 1024 x 64-bit data array, synchronous write, combinational read
module data_memory
  import memory_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  dmem_idx_t idx,
  input  xlen_t     wdata,
  output xlen_t     rdata
);

  // Zero at time zero and deliberately never cleared by reset.
  xlen_t mem_q [DMEM_DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - MEM pipeline stage: data memory access plus MEM/WB register
module memory
  import memory_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ex_mem_rd,
  input  logic                 ex_mem_Memwrite,
  input  logic                 ex_mem_Memread,
  input  logic                 ex_mem_MemtoReg,
  input  logic                 ex_mem_Regwrite,
  input  logic [XLEN-1:0]      ex_mem_alu_result,
  input  logic [XLEN-1:0]      ex_mem_rs2,
  output logic [REG_IDX_W-1:0] mem_wb_rd,
  output logic                 mem_wb_MemtoReg,
  output logic [XLEN-1:0]      mem_wb_alu_result,
  output logic [XLEN-1:0]      mem_wb_mem_data,
  output logic                 mem_wb_RegWrite
);

  dmem_idx_t dmem_idx;
  xlen_t     dmem_rdata;
  logic      dmem_we;
  mem_wb_t   mem_wb_d;
  mem_wb_t   mem_wb_q;

  assign dmem_idx = dmem_index(ex_mem_alu_result);
  assign dmem_we  = ex_mem_Memwrite & rst_n;

  data_memory u_data_memory (
    .clk   (clk),
    .we    (dmem_we),
    .idx   (dmem_idx),
    .wdata (ex_mem_rs2),
    .rdata (dmem_rdata)
  );

  // rdata is sampled before the same-edge store lands, giving read-before-write.
  always_comb begin
    mem_wb_d            = '0;
    mem_wb_d.rd         = ex_mem_rd;
    mem_wb_d.mem_to_reg = ex_mem_MemtoReg;
    mem_wb_d.reg_write  = ex_mem_Regwrite;
    mem_wb_d.alu_result = ex_mem_alu_result;
    mem_wb_d.mem_data   = ex_mem_Memread ? dmem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign mem_wb_rd         = mem_wb_q.rd;
  assign mem_wb_MemtoReg   = mem_wb_q.mem_to_reg;
  assign mem_wb_RegWrite   = mem_wb_q.reg_write;
  assign mem_wb_alu_result = mem_wb_q.alu_result;
  assign mem_wb_mem_data   = mem_wb_q.mem_data;

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for the memory stage
module tb_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_Memwrite;
  logic        ex_mem_Memread;
  logic        ex_mem_MemtoReg;
  logic        ex_mem_Regwrite;
  logic [63:0] ex_mem_alu_result;
  logic [63:0] ex_mem_rs2;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_MemtoReg;
  logic [63:0] mem_wb_alu_result;
  logic [63:0] mem_wb_mem_data;
  logic        mem_wb_RegWrite;

  int compared   = 0;
  int mismatched = 0;

  memory dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_Memwrite   (ex_mem_Memwrite),
    .ex_mem_Memread    (ex_mem_Memread),
    .ex_mem_MemtoReg   (ex_mem_MemtoReg),
    .ex_mem_Regwrite   (ex_mem_Regwrite),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rs2        (ex_mem_rs2),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_MemtoReg   (mem_wb_MemtoReg),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_mem_data   (mem_wb_mem_data),
    .mem_wb_RegWrite   (mem_wb_RegWrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic [4:0] rd, input logic wr, input logic rdn,
                       input logic m2r, input logic rw, input logic [63:0] alu, input logic [63:0] rs2);
    rst_n             = rstn;
    ex_mem_rd         = rd;
    ex_mem_Memwrite   = wr;
    ex_mem_Memread    = rdn;
    ex_mem_MemtoReg   = m2r;
    ex_mem_Regwrite   = rw;
    ex_mem_alu_result = alu;
    ex_mem_rs2        = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stage(input string tag, input logic [4:0] rd, input logic m2r, input logic rw,
                             input logic [63:0] alu, input logic [63:0] data);
    check({tag, ".rd"},       {59'b0, mem_wb_rd}, {59'b0, rd});
    check({tag, ".memtoreg"}, {63'b0, mem_wb_MemtoReg}, {63'b0, m2r});
    check({tag, ".regwrite"}, {63'b0, mem_wb_RegWrite}, {63'b0, rw});
    check({tag, ".alu"},      mem_wb_alu_result, alu);
    check({tag, ".data"},     mem_wb_mem_data, data);
  endtask

  initial begin
    // Reset for two edges with every input nonzero, including a store to addr 16.
    drive(1'b0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 64'd16, 64'hDEAD);
    step();
    step();
    check_stage("reset", 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);

    drive(1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 64'd2, 64'd0);
    step();
    check_stage("fresh_load", 5'd3, 1'b0, 1'b1, 64'd2, 64'd0);

    // Word 2 must still be zero: the store during reset was suppressed.
    drive(1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 64'd16, 64'd0);
    step();
    check("reset_no_write", mem_wb_mem_data, 64'd0);

    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd16, 64'd42);
    step();
    check("store_edge1.data", mem_wb_mem_data, 64'd0);
    drive(1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 64'd16, 64'd0);
    step();
    check("store_then_load", mem_wb_mem_data, 64'd42);

    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd16, 64'd5);
    step();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'd16, 64'd99);
    step();
    check("rbw.old_data", mem_wb_mem_data, 64'd5);
    drive(1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 64'd16, 64'd0);
    step();
    check("rbw.new_data", mem_wb_mem_data, 64'd99);

    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2008, 64'h1234);
    step();
    drive(1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0008, 64'd0);
    step();
    check("alias_0008", mem_wb_mem_data, 64'h1234);
    drive(1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 64'h000F, 64'd0);
    step();
    check("alias_000F", mem_wb_mem_data, 64'h1234);
    drive(1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_E008, 64'd0);
    step();
    check_stage("alias_high", 5'd8, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_E008, 64'h1234);

    drive(1'b1, 5'd17, 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    step();
    check_stage("passthru", 5'd17, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

    // Mid-operation reset with an attempted store of 7 to word 2.
    drive(1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 64'd16, 64'd7);
    step();
    check_stage("mid_reset", 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 64'd16, 64'd0);
    step();
    check_stage("post_reset", 5'd10, 1'b1, 1'b0, 64'd16, 64'd99);
    drive(1'b1, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1, 64'd8, 64'd0);
    step();
    check("reset_keeps_mem", mem_wb_mem_data, 64'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
